// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module   : fifo_rd_pkg
// Purpose  : Shared constants for the dual-clock byte FIFO read side. The
//            FIFO and its drain both take the read latency from here, so the
//            two cannot disagree.
// Contents : FIFO_RD_LAT   - cycles from accepted pop to read-valid strobe
//            FIFO_RD_WIDTH - default data width
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  localparam int FIFO_RD_LAT   = 2;
  localparam int FIFO_RD_WIDTH = 8;

endpackage : fifo_rd_pkg

`default_nettype wire

// File: rtl/fifo_rd_skid.sv
// ============================================================================
// Module   : fifo_rd_skid
// Purpose  : Circular skid buffer of DEPTH entries. Head entry is presented
//            combinationally; a write while full is accepted only when a read
//            frees the head slot in the same cycle.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            wr_en, wr_data   - write strobe and data
//            rd_en            - pop the head entry (ignored when empty)
//            rd_data          - head entry
//            count            - occupancy, 0..DEPTH
//            full, empty      - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = FIFO_RD_WIDTH,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = mem[rd_ptr];

  assign do_rd = rd_en & ~empty;
  // When full, wr_ptr == rd_ptr: the incoming byte overwrites the slot that
  // is being read out this very cycle, so it must only happen alongside a read.
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Cleared so that the head data reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : fifo_rd_skid

`default_nettype wire

// File: rtl/fifo_rd_drain.sv
// ============================================================================
// Module   : fifo_rd_drain
// Purpose  : Read-side consumer of the dual-clock byte FIFO. Pops while the
//            FIFO is non-empty and skid credit remains, tracks the fixed read
//            latency, and presents returned bytes on a framed valid/ready
//            stream.
// Ports    : clk, rst_n            - read clock, asynchronous active-low reset
//            en                    - allow new pops
//            rempty                - FIFO empty flag
//            rinc                  - pop request to FIFO
//            rdata, rvalid         - FIFO read data and read-valid strobe
//            out_valid, out_ready  - output stream handshake
//            out_data, out_last    - output byte and end-of-frame marker
//            err                   - sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = FIFO_RD_WIDTH,
  parameter int LAT   = FIFO_RD_LAT,
  parameter int SKID  = 4,
  parameter int FRAME = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rempty,
  output logic             rinc,
  input  logic [WIDTH-1:0] rdata,
  input  logic             rvalid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             err
);

  localparam int INF_W = $clog2(LAT + 1) + 1;
  localparam int CNT_W = $clog2(SKID + 1);
  localparam int SUM_W = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;
  localparam int FRM_W = $clog2(FRAME);

  if (SKID < LAT + 1) begin : g_skid_depth_check
    $error("fifo_rd_drain: SKID must be at least LAT+1");
  end
  if (FRAME < 2) begin : g_frame_check
    $error("fifo_rd_drain: FRAME must be at least 2");
  end

  logic [INF_W-1:0] inflight;
  logic [FRM_W-1:0] frame_cnt;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] occupancy;
  logic             skid_full;
  logic             skid_empty;
  logic             credit;
  logic             pop;
  logic             handshake;
  logic             ret;
  logic             land;
  logic             drop;

  // Credit counts bytes already owed to us as well as bytes held, so every
  // byte that returns is guaranteed a slot. Only registered state feeds it;
  // out_ready does not reach rinc.
  assign occupancy = SUM_W'(inflight) + SUM_W'(count);
  assign credit    = (occupancy < SUM_W'(SKID));
  // rst_n gates the pop so the FIFO sees no request while reset is held.
  assign pop       = rst_n & en & ~rempty & credit;
  assign rinc      = pop;

  assign out_valid = ~skid_empty;
  assign handshake = out_valid & out_ready;
  assign out_last  = out_valid & (frame_cnt == FRM_W'(FRAME - 1));

  // A returning byte is legal only if a pop is outstanding and there is room
  // (a full buffer frees a slot when the head leaves this cycle).
  assign ret  = rvalid & (inflight != '0);
  assign land = ret & (~skid_full | handshake);
  assign drop = rvalid & ~land;

  fifo_rd_skid #(
    .WIDTH (WIDTH),
    .DEPTH (SKID)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (land),
    .wr_data (rdata),
    .rd_en   (handshake),
    .rd_data (out_data),
    .count   (count),
    .full    (skid_full),
    .empty   (skid_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= '0;
      frame_cnt <= '0;
      err       <= 1'b0;
    end else begin
      case ({pop, ret})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
      if (handshake) begin
        frame_cnt <= (frame_cnt == FRM_W'(FRAME - 1)) ? '0 : frame_cnt + FRM_W'(1);
      end
      if (drop) begin
        err <= 1'b1;
      end
    end
  end

endmodule : fifo_rd_drain

`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
// ============================================================================
// Module   : tb_fifo_rd_drain
// Purpose  : Self-checking bench for fifo_rd_drain. Contains a FIFO read-side
//            model (queue plus two-cycle read pipeline) and a behavioural
//            model of the drain built from byte counts and an ordered queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_drain;

  localparam int W     = 8;
  localparam int LAT   = 2;
  localparam int SKID  = 4;
  localparam int FRAME = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         rempty = 1'b1;
  logic         rinc;
  logic [W-1:0] rdata = '0;
  logic         rvalid = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         err;

  always #5 clk = ~clk;

  fifo_rd_drain #(
    .WIDTH (W),
    .LAT   (LAT),
    .SKID  (SKID),
    .FRAME (FRAME)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rempty    (rempty),
    .rinc      (rinc),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err)
  );

  int checks   = 0;
  int failures = 0;

  // FIFO environment
  logic [W-1:0] fifo_q[$];
  logic         p1_v = 1'b0;
  logic [W-1:0] p1_d = '0;

  // Behavioural model: bytes popped but not yet stored, bytes stored, and
  // the order the bytes must come out in.
  int           infl_m = 0;
  int           held_m = 0;
  int           hs_cnt = 0;
  logic [W-1:0] exp_order[$];

  // Observation counters for the literal expectations
  int cyc = 0;
  int rinc_cnt = 0;
  int valid_cnt = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc = -1;
  int rinc_cyc = -1;
  int last_cnt = 0;
  int last_idx = -1;
  logic [W-1:0] first_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_counters();
    hs_cnt = 0; rinc_cnt = 0; valid_cnt = 0; first_valid_cyc = -1;
    last_hs_cyc = -1; rinc_cyc = -1; last_cnt = 0; last_idx = -1;
  endtask

  // One clock: compare at the falling edge, advance the model, then update
  // the FIFO environment just after the rising edge.
  task automatic step();
    logic exp_rinc;
    logic exp_valid;
    logic pop_now;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_rinc", rinc, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err", err, 0);
      pop_now = 1'b0;
    end else begin
      exp_valid = (held_m > 0);
      exp_rinc  = en && (fifo_q.size() > 0) && (infl_m + held_m < SKID);
      chk("rinc", rinc, exp_rinc);
      chk("out_valid", out_valid, exp_valid);
      chk("out_last", out_last, exp_valid && ((hs_cnt % FRAME) == FRAME - 1));
      chk("err", err, 0);
      if (exp_valid && exp_order.size() > 0) chk("out_data", out_data, exp_order[0]);
      pop_now = rinc;
      if (rinc) begin rinc_cnt++; rinc_cyc = cyc; end
      if (out_valid) begin
        if (first_valid_cyc < 0) begin first_valid_cyc = cyc; first_data = out_data; end
        valid_cnt++;
      end
      if (exp_valid && out_ready) begin
        if (out_last) begin last_cnt++; last_idx = hs_cnt; end
        held_m--;
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_order.size() > 0) void'(exp_order.pop_front());
      end
      if (rvalid) begin infl_m--; held_m++; end
      if (exp_rinc) infl_m++;
    end
    @(posedge clk);
    #1;
    rvalid = p1_v;
    rdata  = p1_d;
    p1_v   = 1'b0;
    if (pop_now && fifo_q.size() > 0) begin
      p1_v = 1'b1;
      p1_d = fifo_q.pop_front();
    end
    rempty = (fifo_q.size() == 0);
  endtask

  task automatic push_bytes(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(W'(start + i));
      exp_order.push_back(W'(start + i));
    end
    rempty = (fifo_q.size() == 0);
  endtask

  // Reset is applied to the drain and the FIFO model together.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    fifo_q.delete(); exp_order.delete();
    p1_v = 1'b0; rvalid = 1'b0; rdata = '0;
    infl_m = 0; held_m = 0;
    clear_counters();
    rempty = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (hs_cnt < n && k < budget) begin step(); k++; end
    if (hs_cnt < n) chk({nm, "_timeout"}, hs_cnt, n);
  endtask

  initial begin
    // Reset with a non-empty FIFO and en high: no pop may escape.
    en = 1'b1;
    rempty = 1'b0;
    for (int i = 0; i < 3; i++) step();
    fifo_q.delete();
    rempty = 1'b1;
    rst_n = 1'b1;
    clear_counters();
    step();

    // Single byte
    out_ready = 1'b1;
    push_bytes(1, 8'hA5);
    for (int i = 0; i < 8; i++) step();
    chk("single_rinc_pulses", rinc_cnt, 1);
    chk("single_valid_cycles", valid_cnt, 1);
    chk("single_latency", first_valid_cyc - rinc_cyc, 3);
    chk("single_data", first_data, 8'hA5);

    // Streaming 300 bytes
    do_reset(2);
    push_bytes(300, 0);
    wait_hs(300, 400, "stream");
    for (int i = 0; i < 3; i++) step();
    chk("stream_count", hs_cnt, 300);
    chk("stream_last_cnt", last_cnt, 1);
    chk("stream_last_idx", last_idx, 255);
    chk("stream_rate", last_hs_cyc - first_valid_cyc, 299);

    // Backpressure
    do_reset(2);
    push_bytes(20, 8'h40);
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("bp_rinc_stopped", rinc, 0);
    chk("bp_held", rinc_cnt - hs_cnt, SKID);
    out_ready = 1'b1;
    wait_hs(20, 60, "bp");
    for (int i = 0; i < 4; i++) step();
    chk("bp_total", hs_cnt, 20);
    chk("bp_pops", rinc_cnt, 20);
    chk("bp_err", err, 0);

    // en toggling
    do_reset(2);
    push_bytes(10, 8'h80);
    begin
      int k;
      k = 0;
      while (rinc_cnt == 0 && k < 20) begin step(); k++; end
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("en_pops", rinc_cnt, 1);
    chk("en_drained", hs_cnt, 1);
    chk("en_no_rinc", rinc, 0);
    en = 1'b1;
    wait_hs(10, 50, "en_resume");
    chk("en_resume_total", hs_cnt, 10);

    // Reset in the middle of a frame
    do_reset(2);
    push_bytes(300, 0);
    wait_hs(100, 150, "mid");
    chk("mid_inflight", infl_m, 2);
    do_reset(2);
    push_bytes(300, 8'h33);
    wait_hs(300, 400, "post");
    for (int i = 0; i < 3; i++) step();
    chk("post_last_cnt", last_cnt, 1);
    chk("post_last_idx", last_idx, 255);
    chk("post_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_rd_drain

`default_nettype wire
